sfifo_rd_stream: RTL and testbench

//  Protected read-side engine for a sfifo built with SHOW_AHEAD=0 (q valid 1 clk after re).
//  On a start command it drains exactly len beats from the FIFO and presents them as a

---
 rtl/sfifo_rd_stream.sv | 213 +++++++++++++++++++++
 tb/tb_sfifo_rd_stream.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_rd_stream.sv
// sfifo_rd_stream
// Read-side engine for a non-show-ahead sync FIFO (q valid one clock after re).
// A start command drains exactly len beats and presents them on a valid/ready
// stream. Reads are credit-limited so the FIFO is never read while empty and the
// 2-entry output buffer can never overflow, even with a read still in flight.

module sfifo_rd_stream #(
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          fifo_re,
  input  logic [DW-1:0] fifo_q,
  input  logic          fifo_rempty,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;

  // transfer bookkeeping
  logic [LW-1:0] len_r;
  logic [LW-1:0] issued_r;
  logic [LW-1:0] accepted_r;
  logic [LW-1:0] acc_inc_s;

  // read pipeline and output buffer (head_r is the entry shown on m_data)
  logic          rd_pend_r;
  logic [1:0]    buf_cnt_r;
  logic [DW-1:0] head_r;
  logic [DW-1:0] tail_r;

  logic          run_s;
  logic          pop_s;
  logic          push_s;
  logic          last_pop_s;
  logic          fifo_re_s;
  logic [LW+1:0] occ_s;

  // Datapath qualifiers: handshake, credit check and read enable.
  always_comb begin
    run_s      = (state_r == ST_RUN);
    pop_s      = (buf_cnt_r != 2'd0) & m_ready;
    push_s     = rd_pend_r;
    acc_inc_s  = accepted_r + {{(LW-1){1'b0}}, 1'b1};
    last_pop_s = run_s & pop_s & (acc_inc_s == len_r);
    // Occupancy the buffer will hold after this edge, counting the beat that
    // is already on its way from the FIFO. Wide enough that it cannot wrap.
    occ_s      = {{LW{1'b0}}, buf_cnt_r}
               + {{(LW+1){1'b0}}, rd_pend_r}
               - {{(LW+1){1'b0}}, pop_s};
    fifo_re_s  = run_s
               & ~fifo_rempty
               & (issued_r != len_r)
               & (occ_s < {{LW{1'b0}}, 2'd2});
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a start seen outside IDLE is ignored.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len == {LW{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_pop_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs; stream outputs come straight from the buffer registers.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      ST_RUN: begin
        busy = 1'b1;
        done = 1'b0;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
    fifo_re = fifo_re_s;
    m_valid = (buf_cnt_r != 2'd0);
    m_data  = head_r;
  end

  // Length latch plus issued/accepted beat counters, both capped at len.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r      <= {LW{1'b0}};
      issued_r   <= {LW{1'b0}};
      accepted_r <= {LW{1'b0}};
    end else if (state_r == ST_IDLE) begin
      if (start) begin
        len_r      <= len;
        issued_r   <= {LW{1'b0}};
        accepted_r <= {LW{1'b0}};
      end else begin
        len_r      <= len_r;
      end
    end else if (run_s) begin
      if (fifo_re_s) begin
        issued_r <= issued_r + {{(LW-1){1'b0}}, 1'b1};
      end else begin
        issued_r <= issued_r;
      end
      if (pop_s && (accepted_r != len_r)) begin
        accepted_r <= acc_inc_s;
      end else begin
        accepted_r <= accepted_r;
      end
    end else begin
      len_r <= len_r;
    end
  end

  // Read-in-flight flag: the beat requested this cycle lands next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r <= 1'b0;
    end else begin
      rd_pend_r <= fifo_re_s;
    end
  end

  // Two-entry output buffer: head is presented, tail is the second beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt_r <= 2'd0;
      head_r    <= {DW{1'b0}};
      tail_r    <= {DW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (buf_cnt_r == 2'd0) begin
            head_r <= fifo_q;
          end else begin
            tail_r <= fifo_q;
          end
          buf_cnt_r <= buf_cnt_r + 2'd1;
        end
        2'b01: begin
          head_r    <= tail_r;
          buf_cnt_r <= buf_cnt_r - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new beat replaces whatever leaves.
          if (buf_cnt_r == 2'd1) begin
            head_r <= fifo_q;
          end else begin
            head_r <= tail_r;
            tail_r <= fifo_q;
          end
        end
        default: begin
          buf_cnt_r <= buf_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Bench for sfifo_rd_stream: a FIFO model feeds the DUT, stimulus pushes the
// words each transfer must deliver into a queue, and a monitor pops and compares
// on every stream handshake while also watching read safety and done pulses.

module tb_sfifo_rd_stream;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          fifo_re;
  logic [DW-1:0] fifo_q;
  logic          fifo_rempty;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  // FIFO model (non-show-ahead): write side driven by the bench
  logic          fifo_wr;
  logic [DW-1:0] fifo_wdata;
  logic [DW-1:0] fmem [0:1023];
  logic [9:0]    fwp;
  logic [9:0]    frp;

  int            n_tests;
  int            n_fail;
  logic [DW-1:0] exp_q[$];
  int            hs_cnt;
  int            rd_cnt;
  int            done_cnt;
  logic          prev_v;
  logic          prev_r;
  logic          prev_done;
  logic [DW-1:0] prev_d;
  logic [DW-1:0] mon_exp;

  sfifo_rd_stream #(.DW(DW), .LW(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .fifo_re     (fifo_re),
    .fifo_q      (fifo_q),
    .fifo_rempty (fifo_rempty),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: q updates one clock after re; empty comes from the pointers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwp    <= 10'd0;
      frp    <= 10'd0;
      fifo_q <= 32'd0;
    end else begin
      if (fifo_wr) begin
        fmem[fwp] <= fifo_wdata;
        fwp       <= fwp + 10'd1;
      end
      if (fifo_re) begin
        fifo_q <= fmem[frp];
        frp    <= frp + 10'd1;
      end
    end
  end
  assign fifo_rempty = (fwp == frp);

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: scoreboard pops, read safety, hold-under-stall, single done pulse.
  initial begin
    prev_v = 1'b0; prev_r = 1'b0; prev_done = 1'b0; prev_d = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0; prev_r = 1'b0; prev_done = 1'b0;
        rd_cnt = hs_cnt;
      end else begin
        if (prev_v && !prev_r) begin
          check("stall_valid_hold", m_valid, 32'd1);
          check("stall_data_hold", m_data, prev_d);
        end
        if (m_valid && m_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL extra_beat: actual=%h required=no beat at %0t", m_data, $time);
          end else begin
            mon_exp = exp_q.pop_front();
            check("beat_data", m_data, mon_exp);
          end
        end
        if (fifo_re) begin
          rd_cnt++;
          check("read_while_empty", fifo_rempty, 32'd0);
          check("read_ahead_bound", ((rd_cnt - hs_cnt) <= 2), 32'd1);
        end
        if (done) begin
          done_cnt++;
          check("done_single_pulse", prev_done, 32'd0);
        end
        prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_done = done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_busy"}, busy, 32'd0);
    check({name, "_done"}, done, 32'd0);
    check({name, "_m_valid"}, m_valid, 32'd0);
    check({name, "_fifo_re"}, fifo_re, 32'd0);
    check({name, "_m_data"}, m_data, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; fifo_wr = 1'b0; m_ready = 1'b0;
    exp_q.delete();
    tick(); tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_word(input logic [DW-1:0] d, input bit to_exp);
    fifo_wr = 1'b1; fifo_wdata = d;
    if (to_exp) exp_q.push_back(d);
    tick();
    fifo_wr = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick(); k++;
    end
    check(name, (done_cnt != d0), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] d1 [4];
    logic [DW-1:0] d2 [8];
    int re_cnt, h0, d0, k, lw, pre, rem;
    watchdog_arm();
    rst_n = 1'b0; start = 1'b0; len = 16'd0; m_ready = 1'b0;
    fifo_wr = 1'b0; fifo_wdata = 32'd0;
    tick(); tick();
    do_reset();

    // 1: four preloaded beats, ready high, exact cycle timing
    for (int i = 0; i < 4; i++) begin d1[i] = $urandom; push_word(d1[i], 1'b1); end
    m_ready = 1'b1; start = 1'b1; len = 16'd4;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t1_fifo_re", fifo_re, (c >= 1 && c <= 4));
      check("t1_m_valid", m_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check("t1_m_data", m_data, d1[c-3]);
      check("t1_done", done, (c == 7));
      check("t1_busy", busy, (c >= 1 && c <= 7));
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("t1_all_beats", exp_q.size(), 32'd0);

    // 2: backpressure for six clocks, then sustained drain with no bubbles
    do_reset();
    for (int i = 0; i < 8; i++) begin d2[i] = $urandom; push_word(d2[i], 1'b1); end
    m_ready = 1'b0; start = 1'b1; len = 16'd8; re_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (fifo_re) re_cnt++;
      if (c == 6) begin
        check("t2_held_valid", m_valid, 32'd1);
        check("t2_held_data", m_data, d2[0]);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 6) m_ready = 1'b1;
    end
    check("t2_reads_while_stalled", re_cnt, 32'd2);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t2_no_bubble", m_valid, 32'd1);
      @(posedge clk); #1;
    end
    wait_done(20, "t2_done_seen");
    check("t2_all_beats", exp_q.size(), 32'd0);

    // 3: empty FIFO, beats trickle in at T5, T9, T10
    do_reset();
    m_ready = 1'b1; h0 = hs_cnt; d0 = done_cnt; len = 16'd3;
    for (int c = 0; c < 30; c++) begin
      start = (c == 0);
      if (c == 5 || c == 9 || c == 10) begin
        fifo_wr = 1'b1; fifo_wdata = $urandom; exp_q.push_back(fifo_wdata);
      end else begin
        fifo_wr = 1'b0;
      end
      tick();
    end
    fifo_wr = 1'b0; start = 1'b0;
    check("t3_beats", hs_cnt - h0, 32'd3);
    check("t3_done_count", done_cnt - d0, 32'd1);

    // 4: zero-length command
    do_reset();
    start = 1'b1; len = 16'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t4_done", done, (c == 1));
      check("t4_busy", busy, (c == 1));
      check("t4_fifo_re", fifo_re, 32'd0);
      check("t4_m_valid", m_valid, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
    end

    // 5: asynchronous reset mid-transfer, then a fresh transfer
    do_reset();
    for (int i = 0; i < 6; i++) push_word($urandom, 1'b1);
    m_ready = 1'b1; start = 1'b1; len = 16'd6;
    tick(); start = 1'b0;
    h0 = hs_cnt; k = 0;
    while ((hs_cnt - h0) < 2 && k < 20) begin tick(); k++; end
    check("t5_reached_beat2", ((hs_cnt - h0) >= 2), 32'd1);
    #2;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t5_async");
    tick(); tick();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (4) tick();
    check("t5_no_done", done_cnt, d0);
    for (int i = 0; i < 2; i++) push_word($urandom, 1'b1);
    h0 = hs_cnt; start = 1'b1; len = 16'd2;
    tick(); start = 1'b0;
    wait_done(20, "t5_done_after_reset");
    check("t5_beats_after_reset", hs_cnt - h0, 32'd2);
    check("t5_all_beats", exp_q.size(), 32'd0);

    // 6: start during RUN is ignored; random ready
    do_reset();
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b1);
    for (int i = 0; i < 5; i++) push_word($urandom, 1'b0);
    h0 = hs_cnt; d0 = done_cnt;
    for (int c = 0; c < 60; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      start = (c == 0) || (c == 2);
      len = (c == 0) ? 16'd3 : 16'd5;
      tick();
    end
    start = 1'b0;
    check("t6_beats", hs_cnt - h0, 32'd3);
    check("t6_done_count", done_cnt - d0, 32'd1);
    check("t6_all_beats", exp_q.size(), 32'd0);

    // Random transfers: random length, prefill, FIFO refill gaps and ready
    do_reset();
    for (int it = 0; it < 25; it++) begin
      lw = $urandom_range(0, 12);
      pre = $urandom_range(0, lw);
      for (int i = 0; i < pre; i++) push_word($urandom, 1'b1);
      rem = lw - pre;
      h0 = hs_cnt; d0 = done_cnt; k = 0;
      start = 1'b1; len = 16'(lw);
      while (done_cnt == d0 && k < 400) begin
        m_ready = ($urandom_range(0, 3) != 0);
        if (rem > 0 && $urandom_range(0, 1) == 1) begin
          fifo_wr = 1'b1; fifo_wdata = $urandom; exp_q.push_back(fifo_wdata); rem--;
        end else begin
          fifo_wr = 1'b0;
        end
        tick();
        start = 1'b0;
        k++;
      end
      fifo_wr = 1'b0;
      check("rnd_done_count", done_cnt - d0, 32'd1);
      check("rnd_beats", hs_cnt - h0, 32'(lw));
      check("rnd_all_beats", exp_q.size(), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic watchdog_arm();
    fork
      begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
    join_none
  endtask

endmodule
